// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage next-PC logic.
// Optional feature: RVC_EN (compressed-instruction support).
package pc_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSN_BYTES  = 4;
    localparam int unsigned CINSN_BYTES = 2;

    typedef logic [XLEN-1:0] pc_t;

endpackage : pc_pkg

// File: rtl/pc_adder.sv
// XLEN-wide adder of a PC value and a small constant increment, with carry-out.
module pc_adder
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = pc_pkg::XLEN,
    parameter int unsigned INC  = INSN_BYTES
) (
    input  logic [XLEN-1:0] a,
    output logic [XLEN-1:0] sum,
    output logic            carry
);

    // Widen by one bit so the carry-out falls out of the addition directly.
    always_comb begin
        {carry, sum} = {1'b0, a} + (XLEN+1)'(INC);
    end

endmodule : pc_adder

// File: rtl/pc_plus4.sv
// Next-sequential-PC generator for the fetch stage: combinational pc+4 with
// wrap/misalign flags, plus a registered copy for the decode stage.
// Optional feature: RVC_EN adds is_c/pc_next (+2 or +4 increment) and
// relaxes the alignment check to halfword.
module pc_plus4
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = pc_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            en,
`ifdef RVC_EN
    input  logic            is_c,
    output logic [XLEN-1:0] pc_next,
`endif
    output logic [XLEN-1:0] pc4,
    output logic            wrap,
    output logic            misalign,
    output logic [XLEN-1:0] pc4_q,
    output logic            wrap_q,
    output logic            misalign_q
);

    logic            carry4;
    logic [XLEN-1:0] pc4_d;
    logic            wrap_d;
    logic            misalign_d;

    pc_adder #(
        .XLEN (XLEN),
        .INC  (INSN_BYTES)
    ) u_add4 (
        .a     (pc),
        .sum   (pc4),
        .carry (carry4)
    );

`ifdef RVC_EN
    logic [XLEN-1:0] pc2;
    logic            carry2;

    pc_adder #(
        .XLEN (XLEN),
        .INC  (CINSN_BYTES)
    ) u_add2 (
        .a     (pc),
        .sum   (pc2),
        .carry (carry2)
    );

    // Select the increment for the current instruction size; wrap follows the selected sum.
    always_comb begin
        pc_next  = is_c ? pc2 : pc4;
        wrap     = is_c ? carry2 : carry4;
        misalign = pc[0];
    end
`else
    // Fixed 4-byte step: wrap is the +4 carry, word alignment required.
    always_comb begin
        wrap     = carry4;
        misalign = |pc[1:0];
    end
`endif

    // Capture the combinational results when enabled, otherwise hold.
    always_comb begin
        pc4_d      = pc4_q;
        wrap_d     = wrap_q;
        misalign_d = misalign_q;
        if (en) begin
            pc4_d      = pc4;
            wrap_d     = wrap;
            misalign_d = misalign;
        end
    end

    // Output register bank, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc4_q      <= '0;
            wrap_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc4_q      <= pc4_d;
            wrap_q     <= wrap_d;
            misalign_q <= misalign_d;
        end
    end

endmodule : pc_plus4

// File: tb/tb_pc_plus4.sv
// Self-checking bench for pc_plus4 (also exercises RVC_EN when defined).
module tb_pc_plus4;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] pc;
    logic         en;
    logic [W-1:0] pc4;
    logic         wrap;
    logic         misalign;
    logic [W-1:0] pc4_q;
    logic         wrap_q;
    logic         misalign_q;
`ifdef RVC_EN
    logic         is_c;
    logic [W-1:0] pc_next;
`endif

    int vectors;
    int miscompares;

    // Reference state for the registered outputs.
    logic [W-1:0] ref_pc4_q;
    logic         ref_wrap_q;
    logic         ref_mis_q;

    pc_plus4 #(.XLEN(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .en         (en),
`ifdef RVC_EN
        .is_c       (is_c),
        .pc_next    (pc_next),
`endif
        .pc4        (pc4),
        .wrap       (wrap),
        .misalign   (misalign),
        .pc4_q      (pc4_q),
        .wrap_q     (wrap_q),
        .misalign_q (misalign_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the architectural rules.
    function automatic longint unsigned step_of(input logic c);
`ifdef RVC_EN
        return c ? 64'd2 : 64'd4;
`else
        return 64'd4;
`endif
    endfunction

    function automatic logic [W-1:0] m_pc4(input logic [W-1:0] p);
        longint unsigned s = longint'(p) + 64'd4;
        return s[W-1:0];
    endfunction

    function automatic logic m_wrap(input logic [W-1:0] p, input logic c);
        longint unsigned s = longint'(p) + step_of(c);
        return s >= 64'h1_0000_0000;
    endfunction

    function automatic logic m_mis(input logic [W-1:0] p);
`ifdef RVC_EN
        return (p % 2) != 0;
`else
        return (p % 4) != 0;
`endif
    endfunction

    function automatic logic cur_c();
`ifdef RVC_EN
        return is_c;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        vectors++;
        if (pc4_q !== '0 || wrap_q !== 1'b0 || misalign_q !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: pc4_q=%h wrap_q=%b mis_q=%b required 0/0/0", pc4_q, wrap_q, misalign_q);
        end
        // combinational path must work while reset is held
        pc = 32'h0000_0010; en = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (pc4 !== 32'h0000_0014 || pc4_q !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: pc4=%h pc4_q=%h required 00000014/00000000", pc4, pc4_q);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        ref_pc4_q = '0; ref_wrap_q = 1'b0; ref_mis_q = 1'b0;
    endtask

    task automatic test_boundaries();
        logic [W-1:0] pcs   [5];
        logic [W-1:0] e_pc4 [5];
        logic         e_wr  [5];
        logic         e_mis [5];
        pcs[0] = 32'h0000_0000; e_pc4[0] = 32'h0000_0004; e_wr[0] = 0; e_mis[0] = 0;
        pcs[1] = 32'hFFFF_FFF4; e_pc4[1] = 32'hFFFF_FFF8; e_wr[1] = 0; e_mis[1] = 0;
        pcs[2] = 32'hFFFF_FFF8; e_pc4[2] = 32'hFFFF_FFFC; e_wr[2] = 0; e_mis[2] = 0;
        pcs[3] = 32'hFFFF_FFFC; e_pc4[3] = 32'h0000_0000; e_wr[3] = 1; e_mis[3] = 0;
        pcs[4] = 32'hFFFF_FFFE; e_pc4[4] = 32'h0000_0002; e_wr[4] = 1; e_mis[4] = 1;
`ifdef RVC_EN
        is_c = 1'b0;
        e_mis[4] = 1'b1;  // bit 0 clear would be aligned; FFFFFFFE has pc[0]=0
        e_mis[4] = 1'b0;
`endif
        for (int i = 0; i < 5; i++) begin
            pc = pcs[i];
            #1;
            vectors++;
            if (pc4 !== e_pc4[i] || wrap !== e_wr[i] || misalign !== e_mis[i]) begin
                miscompares++;
                $display("FAIL boundary[%0d] pc=%h: pc4=%h wrap=%b mis=%b required %h/%b/%b",
                         i, pcs[i], pc4, wrap, misalign, e_pc4[i], e_wr[i], e_mis[i]);
            end
        end
    endtask

    task automatic test_random_comb();
        for (int i = 0; i < 200; i++) begin
            pc = $urandom();
            if (i % 4 == 0) pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
`ifdef RVC_EN
            is_c = 1'($urandom_range(0, 1));
`endif
            #1;
            vectors++;
            if (pc4 !== m_pc4(pc) || wrap !== m_wrap(pc, cur_c()) || misalign !== m_mis(pc)) begin
                miscompares++;
                $display("FAIL comb_rand pc=%h c=%b: pc4=%h wrap=%b mis=%b required %h/%b/%b",
                         pc, cur_c(), pc4, wrap, misalign, m_pc4(pc), m_wrap(pc, cur_c()), m_mis(pc));
            end
`ifdef RVC_EN
            vectors++;
            if (pc_next !== W'(longint'(pc) + step_of(is_c))) begin
                miscompares++;
                $display("FAIL pc_next_rand pc=%h c=%b: pc_next=%h required %h",
                         pc, is_c, pc_next, W'(longint'(pc) + step_of(is_c)));
            end
`endif
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        pc = 32'h0000_1000; en = 1'b1;
`ifdef RVC_EN
        is_c = 1'b0;
`endif
        @(posedge clk); #1;
        vectors++;
        if (pc4_q !== 32'h0000_1004 || wrap_q !== 1'b0 || misalign_q !== 1'b0) begin
            miscompares++;
            $display("FAIL reg_capture: pc4_q=%h wrap_q=%b mis_q=%b required 00001004/0/0", pc4_q, wrap_q, misalign_q);
        end
        @(negedge clk);
        pc = 32'h0000_2000; en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (pc4_q !== 32'h0000_1004) begin
            miscompares++;
            $display("FAIL reg_hold: pc4_q=%h required 00001004", pc4_q);
        end
        ref_pc4_q = 32'h0000_1004; ref_wrap_q = 1'b0; ref_mis_q = 1'b0;
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        pc = 32'hFFFF_FFFE; en = 1'b1;
`ifdef RVC_EN
        is_c = 1'b0;
`endif
        @(posedge clk); #1;
        vectors++;
        if (pc4_q !== 32'h0000_0002 || wrap_q !== 1'b1 || misalign_q !== m_mis(32'hFFFF_FFFE)) begin
            miscompares++;
            $display("FAIL pre_reset_capture: pc4_q=%h wrap_q=%b mis_q=%b required 00000002/1/%b",
                     pc4_q, wrap_q, misalign_q, m_mis(32'hFFFF_FFFE));
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (pc4_q !== '0 || wrap_q !== 1'b0 || misalign_q !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: pc4_q=%h wrap_q=%b mis_q=%b required 0/0/0", pc4_q, wrap_q, misalign_q);
        end
        @(posedge clk); #1;
        vectors++;
        if (pc4_q !== '0 || wrap_q !== 1'b0 || misalign_q !== 1'b0 || pc4 !== 32'h0000_0002) begin
            miscompares++;
            $display("FAIL reset_held_edge: pc4_q=%h wrap_q=%b mis_q=%b pc4=%h required 0/0/0/00000002",
                     pc4_q, wrap_q, misalign_q, pc4);
        end
        @(negedge clk);
        rst = 1'b0;
        pc  = 32'h0000_0040;
        @(posedge clk); #1;
        vectors++;
        if (pc4_q !== 32'h0000_0044 || wrap_q !== 1'b0 || misalign_q !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_capture: pc4_q=%h wrap_q=%b mis_q=%b required 00000044/0/0", pc4_q, wrap_q, misalign_q);
        end
        ref_pc4_q = 32'h0000_0044; ref_wrap_q = 1'b0; ref_mis_q = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            pc = $urandom();
            if (i % 5 == 0) pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            en = 1'($urandom_range(0, 3) != 0);
`ifdef RVC_EN
            is_c = 1'($urandom_range(0, 1));
`endif
            if (en) begin
                ref_pc4_q  = m_pc4(pc);
                ref_wrap_q = m_wrap(pc, cur_c());
                ref_mis_q  = m_mis(pc);
            end
            @(posedge clk); #1;
            vectors++;
            if (pc4_q !== ref_pc4_q || wrap_q !== ref_wrap_q || misalign_q !== ref_mis_q) begin
                miscompares++;
                $display("FAIL b2b[%0d] pc=%h en=%b: pc4_q=%h wrap_q=%b mis_q=%b required %h/%b/%b",
                         i, pc, en, pc4_q, wrap_q, misalign_q, ref_pc4_q, ref_wrap_q, ref_mis_q);
            end
        end
    endtask

`ifdef RVC_EN
    task automatic test_rvc();
        pc = 32'hFFFF_FFFE; is_c = 1'b1;
        #1;
        vectors++;
        if (pc_next !== 32'h0000_0000 || wrap !== 1'b1 || misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL rvc_wrap: pc_next=%h wrap=%b mis=%b required 00000000/1/0", pc_next, wrap, misalign);
        end
        pc = 32'h0000_0002; is_c = 1'b0;
        #1;
        vectors++;
        if (pc_next !== 32'h0000_0006 || wrap !== 1'b0 || misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL rvc_step4: pc_next=%h wrap=%b mis=%b required 00000006/0/0", pc_next, wrap, misalign);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        en  = 1'b0;
        pc  = '0;
`ifdef RVC_EN
        is_c = 1'b0;
`endif
        #1;
        test_reset();
        test_boundaries();
`ifdef RVC_EN
        test_rvc();
`endif
        test_random_comb();
        test_registered();
        test_reset_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pc_plus4
